dcs_former: RTL and testbench

//  Streaming attention-score engine for the DCS transformer datapath.
//  - Loads a 4x4 signed token matrix X, then two 4x4 signed weight matrices Wq, Wk.
//  - Computes Q=X*Wq, K=X*Wk and S=Q*K^T.
//  - Streams the 16 entries of S out row-major, one per cycle.
//  - Sits between the byte-wide input/weight loaders and the 32-bit result sink.

---
 rtl/dcs_former_pkg.sv | 15 +
 rtl/dcs_former_if.sv | 17 +
 rtl/dcs_dot4.sv | 18 +
 rtl/dcs_former.sv | 126 ++++++++++++
 tb/tb_dcs_former.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/dcs_former_pkg.sv
// Shared widths, FSM encoding and element types for the DCS attention-score engine.
package dcs_former_pkg;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int OW   = 32;
   localparam int QW   = 18;
   localparam int SW   = 37;
   localparam int CW   = 5;

   typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, CALC, OUT} state_t;

   typedef logic signed [DW-1:0] elem_t;
   typedef logic signed [QW-1:0] qk_t;
   typedef logic signed [OW-1:0] out_t;
endpackage

// File: rtl/dcs_former_if.sv
// Loader/sink handshake bundle for dcs_former: byte-wide X and weight streams in, S stream out.
interface dcs_former_if;
   import dcs_former_pkg::*;

   logic  i_valid;
   elem_t i_data;
   logic  w_valid;
   elem_t w_data;
   logic  w_ready;
   logic  o_valid;
   out_t  o_data;

   modport master (output i_valid, i_data, w_valid, w_data,
                   input  w_ready, o_valid, o_data);
   modport slave  (input  i_valid, i_data, w_valid, w_data,
                   output w_ready, o_valid, o_data);
endinterface

// File: rtl/dcs_dot4.sv
// Combinational signed 4-term dot product; operands are sign-extended to the sum width
// so every product and the final sum are exact as long as SUMW covers the range.
module dcs_dot4 #(
   parameter int W    = 8,
   parameter int SUMW = 18
) (
   input  logic [3:0][W-1:0]      i_a,
   input  logic [3:0][W-1:0]      i_b,
   output logic signed [SUMW-1:0] o_sum
);
   logic signed [SUMW-1:0] w_prod [4];

   for (genvar k = 0; k < 4; k++) begin : g_prod
      assign w_prod[k] = SUMW'($signed(i_a[k])) * SUMW'($signed(i_b[k]));
   end

   assign o_sum = w_prod[0] + w_prod[1] + w_prod[2] + w_prod[3];
endmodule

// File: rtl/dcs_former.sv
// Attention-score engine: loads X, Wq, Wk, builds Q and K one entry per cycle,
// then streams S = Q*K^T row-major, one 32-bit wrapped entry per cycle.
module dcs_former
   import dcs_former_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   dcs_former_if.slave  bus
);
   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_w_ready;
   logic            r_o_valid;
   out_t            r_o_data;

   elem_t r_x  [N][N];
   elem_t r_wq [N][N];
   elem_t r_wk [N][N];
   qk_t   r_q  [N][N];
   qk_t   r_k  [N][N];

   logic                      w_x_take;
   logic                      w_w_take;
   logic [N-1:0][DW-1:0]      w_a1, w_b1;
   logic [N-1:0][QW-1:0]      w_a2, w_b2;
   qk_t                       w_qk;
   logic signed [SW-1:0]      w_s;
   logic [SW-OW-1:0]          w_unused_s_hi;

   assign w_x_take = ((r_state == IDLE) || (r_state == LOAD_X)) && bus.i_valid;
   assign w_w_take = (r_state == LOAD_W) && r_w_ready && bus.w_valid;

   // cnt[3:2]/cnt[1:0] address row/column; in CALC cnt[4] selects the K pass
   always_comb begin
      w_a1 = '0;
      w_b1 = '0;
      w_a2 = '0;
      w_b2 = '0;
      for (int k = 0; k < N; k++) begin
         w_a1[k] = r_x[r_cnt[3:2]][k];
         w_b1[k] = r_cnt[4] ? r_wk[k][r_cnt[1:0]] : r_wq[k][r_cnt[1:0]];
         w_a2[k] = r_q[r_cnt[3:2]][k];
         w_b2[k] = r_k[r_cnt[1:0]][k];
      end
   end

   dcs_dot4 #(.W(DW), .SUMW(QW)) u_dot_qk (.i_a(w_a1), .i_b(w_b1), .o_sum(w_qk));
   dcs_dot4 #(.W(QW), .SUMW(SW)) u_dot_s  (.i_a(w_a2), .i_b(w_b2), .o_sum(w_s));

   assign w_unused_s_hi = w_s[SW-1:OW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_w_ready <= 1'b0;
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
      end else begin
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
         case (r_state)
            IDLE, LOAD_X: begin
               if (w_x_take) begin
                  if (r_cnt == CW'(N*N-1)) begin
                     r_state   <= LOAD_W;
                     r_cnt     <= '0;
                     r_w_ready <= 1'b1;
                  end else begin
                     r_state <= LOAD_X;
                     r_cnt   <= r_cnt + 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (w_w_take) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == CW'(2*N*N-1)) begin
                     r_state   <= CALC;
                     r_cnt     <= '0;
                     r_w_ready <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(2*N*N-1)) begin
                  r_state <= OUT;
                  r_cnt   <= '0;
               end
            end
            OUT: begin
               r_o_valid <= 1'b1;
               r_o_data  <= w_s[OW-1:0];
               r_cnt     <= r_cnt + 1'b1;
               if (r_cnt == CW'(N*N-1)) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Matrix storage carries no reset: contents are meaningless until reloaded.
   always_ff @(posedge clk) begin
      if (w_x_take)
         r_x[r_cnt[3:2]][r_cnt[1:0]] <= bus.i_data;
      if (w_w_take) begin
         if (r_cnt[4]) r_wk[r_cnt[3:2]][r_cnt[1:0]] <= bus.w_data;
         else          r_wq[r_cnt[3:2]][r_cnt[1:0]] <= bus.w_data;
      end
      if (r_state == CALC) begin
         if (r_cnt[4]) r_k[r_cnt[3:2]][r_cnt[1:0]] <= w_qk;
         else          r_q[r_cnt[3:2]][r_cnt[1:0]] <= w_qk;
      end
   end

   assign bus.w_ready = r_w_ready;
   assign bus.o_valid = r_o_valid;
   assign bus.o_data  = r_o_data;
endmodule

// File: tb/tb_dcs_former.sv
// Directed and random pattern bench for dcs_former with a small matrix golden model.
module tb_dcs_former;
   import dcs_former_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   dcs_former_if bus();
   dcs_former dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   logic signed [7:0] tx [16];
   logic signed [7:0] tw [32];
   logic [31:0]       got [16];
   logic [31:0]       exp_s [16];
   int                lat;
   bit                contig;
   bit                hs_ok;

   function automatic void model();
      longint q [4][4];
      longint k [4][4];
      longint s;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            q[i][j] = 0;
            k[i][j] = 0;
            for (int m = 0; m < 4; m++) begin
               q[i][j] += longint'(tx[i*4+m]) * longint'(tw[m*4+j]);
               k[i][j] += longint'(tx[i*4+m]) * longint'(tw[16+m*4+j]);
            end
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            s = 0;
            for (int m = 0; m < 4; m++) s += q[i][m] * k[j][m];
            exp_s[i*4+j] = s[31:0];
         end
   endfunction

   // Drives 16 X bytes then nw weights; gaps>0 inserts idle cycles and junk on the other stream.
   task automatic drive_pattern(input int gaps, input int nw);
      int b;
      hs_ok = 1'b1;
      bus.w_valid = (gaps != 0);
      bus.w_data  = 8'h5a;
      for (int e = 0; e < 16; e++) begin
         if (gaps != 0) begin
            repeat ($urandom_range(0, 2)) begin
               bus.i_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         bus.i_valid = 1'b1;
         bus.i_data  = tx[e];
         @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      for (int e = 0; e < nw; e++) begin
         if (gaps != 0) begin
            repeat ($urandom_range(0, 2)) begin
               bus.w_valid = 1'b0;
               bus.i_valid = 1'b1;
               bus.i_data  = 8'h7f;
               @(posedge clk); #1;
            end
         end
         bus.w_valid = 1'b1;
         bus.w_data  = tw[e];
         b = 0;
         while (!bus.w_ready && b < 50) begin
            @(posedge clk); #1;
            b++;
         end
         if (b >= 50) hs_ok = 1'b0;
         @(posedge clk); #1;
      end
      bus.i_valid = 1'b0;
      bus.w_valid = (gaps != 0);
      bus.w_data  = 8'h33;
   endtask

   task automatic collect();
      int b = 0;
      contig = 1'b1;
      while (!bus.o_valid && b < 250) begin
         @(posedge clk); #1;
         b++;
      end
      lat = b;
      for (int i = 0; i < 16; i++) begin
         got[i] = bus.o_data;
         if (!bus.o_valid) contig = 1'b0;
         @(posedge clk); #1;
      end
      bus.w_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b0; bus.i_data = '0;
      bus.w_valid = 1'b0; bus.w_data = '0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.w_ready !== 1'b0) begin bad++; $display("FAIL reset_w_ready got=%b exp=0", bus.w_ready); end
      total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid got=%b exp=0", bus.o_valid); end
      total++; if (bus.o_data !== 32'd0) begin bad++; $display("FAIL reset_o_data got=%0d exp=0", bus.o_data); end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_identity(input string name);
      for (int e = 0; e < 16; e++) begin
         tx[e] = (e/4 == e%4) ? 8'sd1 : 8'sd0;
         tw[e] = tx[e];
         tw[16+e] = tx[e];
      end
      drive_pattern(0, 32);
      collect();
      total++; if (!hs_ok) begin bad++; $display("FAIL %s_handshake got=timeout exp=accepted", name); end
      total++; if (lat >= 200) begin bad++; $display("FAIL %s_latency got=%0d exp=<200", name, lat); end
      total++; if (!contig) begin bad++; $display("FAIL %s_contig got=gap exp=16 contiguous", name); end
      for (int i = 0; i < 16; i++) begin
         total++;
         if (got[i] !== ((i/4 == i%4) ? 32'd1 : 32'd0)) begin
            bad++; $display("FAIL %s idx=%0d got=%0d exp=%0d", name, i, got[i], (i/4 == i%4) ? 1 : 0);
         end
      end
      total++; if (bus.o_valid !== 1'b0 || bus.o_data !== 32'd0) begin
         bad++; $display("FAIL %s_after got=%b/%0d exp=0/0", name, bus.o_valid, bus.o_data);
      end
   endtask

   task automatic test_ones();
      for (int e = 0; e < 16; e++) begin tx[e] = 8'sd1; tw[e] = 8'sd1; tw[16+e] = 8'sd1; end
      drive_pattern(0, 32);
      collect();
      total++; if (!contig) begin bad++; $display("FAIL ones_contig got=gap exp=contiguous"); end
      for (int i = 0; i < 16; i++) begin
         total++; if (got[i] !== 32'd64) begin bad++; $display("FAIL ones idx=%0d got=%0d exp=64", i, got[i]); end
      end
   endtask

   task automatic test_neg_diag();
      for (int e = 0; e < 16; e++) begin
         tx[e] = (e/4 == e%4) ? -8'sd128 : 8'sd0;
         tw[e] = tx[e];
         tw[16+e] = tx[e];
      end
      drive_pattern(0, 32);
      collect();
      for (int i = 0; i < 16; i++) begin
         total++;
         if (got[i] !== ((i/4 == i%4) ? 32'd268435456 : 32'd0)) begin
            bad++; $display("FAIL neg_diag idx=%0d got=%0d exp=%0d", i, got[i], (i/4 == i%4) ? 268435456 : 0);
         end
      end
   endtask

   task automatic test_wrap();
      for (int e = 0; e < 16; e++) begin tx[e] = -8'sd128; tw[e] = -8'sd128; tw[16+e] = 8'sd127; end
      drive_pattern(0, 32);
      collect();
      for (int i = 0; i < 16; i++) begin
         total++; if (got[i] !== 32'h0800_0000) begin bad++; $display("FAIL wrap idx=%0d got=%h exp=08000000", i, got[i]); end
      end
   endtask

   task automatic test_gaps();
      for (int e = 0; e < 16; e++) tx[e] = 8'($urandom);
      for (int e = 0; e < 32; e++) tw[e] = 8'($urandom);
      model();
      drive_pattern(1, 32);
      collect();
      total++; if (!hs_ok) begin bad++; $display("FAIL gaps_handshake got=timeout exp=accepted"); end
      total++; if (!contig) begin bad++; $display("FAIL gaps_contig got=gap exp=contiguous"); end
      for (int i = 0; i < 16; i++) begin
         total++; if (got[i] !== exp_s[i]) begin bad++; $display("FAIL gaps idx=%0d got=%h exp=%h", i, got[i], exp_s[i]); end
      end
   endtask

   task automatic test_reset_mid();
      for (int e = 0; e < 16; e++) tx[e] = 8'($urandom);
      for (int e = 0; e < 32; e++) tw[e] = 8'($urandom);
      drive_pattern(0, 5);
      total++; if (bus.w_ready !== 1'b1) begin bad++; $display("FAIL mid_w_ready_pre got=%b exp=1", bus.w_ready); end
      rst_n = 1'b0;
      #2;
      total++; if (bus.w_ready !== 1'b0) begin bad++; $display("FAIL mid_w_ready_rst got=%b exp=0", bus.w_ready); end
      total++; if (bus.o_valid !== 1'b0 || bus.o_data !== 32'd0) begin
         bad++; $display("FAIL mid_out_rst got=%b/%0d exp=0/0", bus.o_valid, bus.o_data);
      end
      bus.w_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_identity("mid_ident");
   endtask

   task automatic test_back_to_back();
      for (int p = 0; p < 100; p++) begin
         for (int e = 0; e < 16; e++) tx[e] = 8'($urandom);
         for (int e = 0; e < 32; e++) tw[e] = 8'($urandom);
         model();
         drive_pattern(p % 2, 32);
         collect();
         total++; if (!hs_ok || !contig) begin bad++; $display("FAIL b2b_flow p=%0d got=hs%0d/contig%0d exp=1/1", p, hs_ok, contig); end
         for (int i = 0; i < 16; i++) begin
            total++;
            if (got[i] !== exp_s[i]) begin bad++; $display("FAIL b2b p=%0d idx=%0d got=%h exp=%h", p, i, got[i], exp_s[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity("ident");
      test_ones();
      test_neg_diag();
      test_wrap();
      test_gaps();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
